wb_mem_responder: RTL and testbench
===================================

Name: wb_mem_responder

Overview:
- Wishbone B4 classic-cycle responder. It is the slave end of the bus the CPU's memory controller drives, with the same 128-bit data width and byte selects.
- Backs a local byte-enabled RAM and inserts a configurable number of wait states.
- Signals err for out-of-range addresses.
- Serves as the on-chip boot/scratch memory and as the bench target for the CPU's bus master.

Parameters:
- DATA_WIDTH, 128: bus data width in bits; must be a power of two ≥ 32.
- DEPTH_LOG2, 10: log2 of the number of DATA_WIDTH words stored.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be aligned to the region size.
- WAIT_STATES, 1: cycles between request acceptance and response; range 0..15.
- RETRY_INTERVAL, 8: used only with the optional feature; range 2..255.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset; asserted when 0.
- wb_adr_i  in  32  byte address. Word index = adr[DEPTH_LOG2+OFF-1:OFF], where OFF = log2(DATA_WIDTH/8).
- wb_dat_i  in  DATA_WIDTH  write data.
- wb_dat_o  out  DATA_WIDTH  read data; valid only while ack is high.
- wb_we_i  in  1  1 = write.
- wb_sel_i  in  DATA_WIDTH/8  byte enables; bit n covers bits [8n+7:8n].
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle valid.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  error termination.
- wb_rty_o  out  1  retry termination.

Behaviour:
- Reset: while rst is 0, state = IDLE, wait counter = 0, and ack, err, rty and dat_o are all 0. Reset may assert in any state. An in-flight write is dropped and the RAM is not modified.
- Request: a request exists when cyc & stb. The responder samples adr, we, sel and dat_i at acceptance (IDLE & request) into holding registers. Later changes to the inputs are ignored.
- FSM states:
  - IDLE: on a request, go to WAIT if WAIT_STATES > 0, otherwise go to RESP.
  - WAIT: count down from WAIT_STATES-1; at 0 go to RESP. If cyc drops, abort to IDLE with no response and no write.
  - RESP: drive exactly one termination for one cycle, then go to IDLE. If cyc is low on entry, suppress the termination and go to IDLE.
- Latency: acceptance edge to termination high = WAIT_STATES+1 cycles.
  - Minimum transfer period is WAIT_STATES+2 cycles, because IDLE lasts one cycle after each response.
  - Back-to-back strobes are therefore served with a one-cycle gap.
- Range check:
  - In range when BASE_ADDR ≤ adr < BASE_ADDR + 2^(DEPTH_LOG2+OFF).
  - In range: terminate with ack.
  - Out of range: terminate with err; no RAM access; dat_o = 0.
  - Low OFF address bits are ignored; unaligned addresses are not an error.
- Write: committed in the RESP cycle with ack, only to bytes whose sel bit is 1. sel = 0 acks with no change.
- Read: RAM read issued so that dat_o holds the word during the ack cycle; dat_o = 0 in every other cycle. Read is independent of sel, so the full word is returned.
- Terminations are mutually exclusive: ack, err and rty are never high together, and each is a single-cycle pulse.
- The RAM holds no initial contents; reset does not clear it.

Optional Feature:
- Macro WB_MEM_RESPONDER_RETRY_EN.
- Defined:
  - An 8-bit counter of accepted in-range requests; reset value 0.
  - The request that brings the count to 0 mod RETRY_INTERVAL (the first request after reset included) terminates with rty instead of ack.
  - No write occurs, dat_o = 0, and the counter still increments.
  - Aborted requests are not counted. err takes precedence over rty.
- Undefined: wb_rty_o is tied to 0 and the counter is absent.

Decomposition:
- Package wb_mem_pkg holds:
  - the FSM state enum (IDLE, WAIT, RESP);
  - the OFF computation function;
  - the termination encoding constants (TERM_ACK, TERM_ERR, TERM_RTY).
- One sub-module, wb_mem_ram: a single-port synchronous RAM with per-byte write enables, DATA_WIDTH × 2^DEPTH_LOG2, one-cycle read.

Test Plan:
- Reset, then write adr 0x10 with dat 0x00112233_44556677_8899AABB_CCDDEEFF and sel 0xFFFF; then read 0x10 → ack exactly 2 cycles after acceptance (WAIT_STATES=1) and dat_o equals the written word.
- Partial write: sel 0x000F with dat 0xDEADBEEF in low bits over a 0xFFFF... word → read returns upper 96 bits unchanged and low 32 bits = 0xDEADBEEF.
- Read adr 0x0000_4000 (just past 16 KiB) → err pulse for 1 cycle, ack = 0, dat_o = 0, RAM unchanged.
- Drop cyc during WAIT on a write to 0x20 → no termination, FSM returns to IDLE, and a later read of 0x20 shows the old data.
- Assert rst low in the RESP cycle of a write → no ack and no write; all outputs are 0 the same cycle, asynchronously.
- With WB_MEM_RESPONDER_RETRY_EN and RETRY_INTERVAL=4, issue 5 reads → terminations rty, ack, ack, ack, rty.

Source files
------------

// File: rtl/wb_mem_pkg.sv
// Shared definitions for the Wishbone memory responder.
//   state_e  : responder FSM states (idle, wait-state countdown, response cycle)
//   term_t   : termination selector (TermAck / TermErr / TermRty)
//   off_bits : number of byte-offset address bits for a given bus width
package wb_mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    typedef logic [1:0] term_t;

    localparam term_t TermAck = 2'd1;
    localparam term_t TermErr = 2'd2;
    localparam term_t TermRty = 2'd3;

    function automatic int unsigned off_bits(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/wb_mem_ram.sv
// Single-port synchronous RAM, DATA_WIDTH x 2^DEPTH_LOG2, per-byte write enables.
// Ports:
//   clk_i   : clock
//   addr_i  : word index
//   be_i    : byte write enables (bit n covers wdata_i[8n+7:8n])
//   wdata_i : write data
//   rdata_o : registered read data, one cycle after addr_i (old data on collision)
// No reset: contents are undefined after power-up and survive reset.
module wb_mem_ram #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                      clk_i,
    input  logic [DEPTH_LOG2-1:0]     addr_i,
    input  logic [DATA_WIDTH/8-1:0]   be_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    output logic [DATA_WIDTH-1:0]     rdata_o
);

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            if (be_i[i]) begin
                mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        rdata_o <= mem[addr_i];
    end

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone B4 classic-cycle responder backed by a local byte-enabled RAM.
// Inserts WAIT_STATES wait cycles, terminates out-of-range accesses with err.
// Optional feature macro: WB_MEM_RESPONDER_RETRY_EN -- every RETRY_INTERVAL-th
// accepted in-range request (first one after reset included) terminates with rty.
// Ports:
//   clk, rst (async, active low)
//   wb_adr_i/wb_dat_i/wb_we_i/wb_sel_i/wb_stb_i/wb_cyc_i : request from master
//   wb_dat_o : read data, non-zero only during a read ack
//   wb_ack_o/wb_err_o/wb_rty_o : single-cycle, mutually exclusive terminations
module wb_mem_responder
    import wb_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 128,
    parameter int unsigned DEPTH_LOG2     = 10,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned WAIT_STATES    = 1,
    parameter int unsigned RETRY_INTERVAL = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic                    wb_we_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_cyc_i,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic                    wb_rty_o
);

    localparam int unsigned Off      = off_bits(DATA_WIDTH);
    localparam logic [3:0]  WaitInit = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [32:0] RegionLo = {1'b0, BASE_ADDR};
    localparam logic [32:0] RegionHi = RegionLo + (33'd1 << (DEPTH_LOG2 + Off));

    state_e                  state_q, state_d;
    logic [3:0]              wait_q, wait_d;
    logic [31:0]             adr_q;
    logic                    we_q;
    logic [DATA_WIDTH/8-1:0] sel_q;
    logic [DATA_WIDTH-1:0]   dat_q;

    logic                    accept;
    logic                    respond;
    logic                    in_range;
    logic                    retry_hit;
    term_t                   term;
    logic [DEPTH_LOG2-1:0]   ram_addr;
    logic [DATA_WIDTH/8-1:0] ram_be;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    assign accept   = (state_q == StIdle) && wb_cyc_i && wb_stb_i;
    // cyc low on entry to RESP suppresses the termination (and hence the write)
    assign respond  = (state_q == StResp) && wb_cyc_i;
    assign in_range = ({1'b0, adr_q} >= RegionLo) && ({1'b0, adr_q} < RegionHi);

`ifdef WB_MEM_RESPONDER_RETRY_EN
    logic [7:0] retry_cnt_q;

    assign retry_hit = (32'(retry_cnt_q) % RETRY_INTERVAL) == 32'd0;

    // Counts only requests that actually terminate in range; aborts are skipped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retry_cnt_q <= 8'd0;
        end else if (respond && in_range) begin
            retry_cnt_q <= retry_cnt_q + 8'd1;
        end
    end
`else
    logic unused_retry_interval;

    assign retry_hit             = 1'b0;
    assign unused_retry_interval = ^RETRY_INTERVAL;
`endif

    always_comb begin
        term = TermAck;
        if (!in_range) begin
            term = TermErr;
        end else if (retry_hit) begin
            term = TermRty;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        wait_d  = WaitInit;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StWait: begin
                if (!wb_cyc_i) begin
                    state_d = StIdle;
                end else if (wait_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            wait_q  <= 4'd0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (accept) begin
                adr_q <= wb_adr_i;
                we_q  <= wb_we_i;
                sel_q <= wb_sel_i;
                dat_q <= wb_dat_i;
            end
        end
    end

    // In IDLE the RAM looks at the live bus address so that a zero-wait-state read
    // has its word ready in the RESP cycle; otherwise it uses the held address.
    assign ram_addr = (state_q == StIdle) ? wb_adr_i[DEPTH_LOG2+Off-1:Off]
                                          : adr_q[DEPTH_LOG2+Off-1:Off];

    always_comb begin
        wb_ack_o = respond && (term == TermAck);
        wb_err_o = respond && (term == TermErr);
        wb_rty_o = respond && (term == TermRty);
        ram_be   = (wb_ack_o && we_q) ? sel_q : '0;
        wb_dat_o = (wb_ack_o && !we_q) ? ram_rdata : '0;
    end

    wb_mem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk_i   (clk),
        .addr_i  (ram_addr),
        .be_i    (ram_be),
        .wdata_i (dat_q),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_wb_mem_responder.sv
module tb_wb_mem_responder;

    localparam int unsigned Ws = 1;
    localparam int unsigned Ri = 4;

    localparam logic [127:0] D0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] D1 = 128'hA5A5A5A5_5A5A5A5A_01234567_89ABCDEF;
    localparam logic [127:0] D2 = 128'hCAFEF00D_12345678_9ABCDEF0_0F1E2D3C;
    localparam logic [127:0] D3 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] D4 = 128'h99999999_88888888_77777777_66666666;
    localparam logic [127:0] Ones = {128{1'b1}};
    localparam logic [127:0] Junk = 128'h0BADC0DE_0BADC0DE_0BADC0DE_0BADC0DE;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  wb_adr_i = '0;
    logic [127:0] wb_dat_i = '0;
    logic [127:0] wb_dat_o;
    logic         wb_we_i = 1'b0;
    logic [15:0]  wb_sel_i = '0;
    logic         wb_stb_i = 1'b0;
    logic         wb_cyc_i = 1'b0;
    logic         wb_ack_o, wb_err_o, wb_rty_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_mem_responder #(
        .DATA_WIDTH     (128),
        .DEPTH_LOG2     (10),
        .BASE_ADDR      (32'h0000_0000),
        .WAIT_STATES    (Ws),
        .RETRY_INTERVAL (Ri)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_we_i  (wb_we_i),
        .wb_sel_i (wb_sel_i),
        .wb_stb_i (wb_stb_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .wb_rty_o (wb_rty_o)
    );

    typedef struct {
        logic [31:0]  adr;
        logic         we;
        logic [15:0]  sel;
        logic [127:0] dat;
        int           exp_term;  // 1 ack, 2 err, 3 rty
        logic [127:0] exp_data;  // checked for reads and errors only
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One classic cycle. term: 0 none (timeout), 1 ack, 2 err, 3 rty.
    // lat counts clock edges from acceptance to the sample that saw the termination.
    task automatic bus_xfer(input logic [31:0] adr, input logic we, input logic [15:0] sel,
                            input logic [127:0] dat, input bit scramble,
                            output int term, output int lat, output logic [127:0] rdata,
                            output bit excl_ok, output bit quiet_ok);
        term = 0;
        lat = 0;
        rdata = '0;
        excl_ok = 1'b1;
        quiet_ok = 1'b1;
        @(negedge clk);
        wb_adr_i = adr;
        wb_we_i  = we;
        wb_sel_i = sel;
        wb_dat_i = dat;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (int'(wb_ack_o) + int'(wb_err_o) + int'(wb_rty_o) > 1) excl_ok = 1'b0;
            if (wb_ack_o || wb_err_o || wb_rty_o) begin
                term  = wb_ack_o ? 1 : (wb_err_o ? 2 : 3);
                lat   = k;
                rdata = wb_dat_o;
                break;
            end
            if (wb_dat_o !== '0) quiet_ok = 1'b0;
            if (scramble) begin
                wb_adr_i = $urandom();
                wb_we_i  = 1'($urandom());
                wb_sel_i = 16'($urandom());
                wb_dat_i = rand128();
            end
        end
        // Keep cyc for one more cycle so a stretched termination would show up.
        wb_stb_i = 1'b0;
        @(negedge clk);
        if (wb_ack_o || wb_err_o || wb_rty_o || wb_dat_o !== '0) quiet_ok = 1'b0;
        wb_cyc_i = 1'b0;
    endtask

    // Reference memory: 8 words, per-byte known mask.
    logic [127:0] m_data  [8];
    logic [15:0]  m_known [8];
    int           m_cnt;

    task automatic model_xfer(input logic [31:0] adr, input logic we, input logic [15:0] sel,
                              input logic [127:0] dat, input string tag);
        int           term, lat, idx, exp_term;
        logic [127:0] rdata, mask;
        bit           excl_ok, quiet_ok, inr;
        inr = adr < 32'h0000_4000;
        idx = int'(adr[6:4]);
        exp_term = 1;
        if (!inr) begin
            exp_term = 2;
        end else begin
`ifdef WB_MEM_RESPONDER_RETRY_EN
            if (m_cnt % Ri == 0) exp_term = 3;
            m_cnt = (m_cnt + 1) % 256;
`endif
        end
        bus_xfer(adr, we, sel, dat, 1'b1, term, lat, rdata, excl_ok, quiet_ok);
        check({tag, "_term"}, 128'(term), 128'(exp_term));
        check({tag, "_lat"}, 128'(lat), 128'(Ws + 1));
        check({tag, "_excl"}, 128'(excl_ok), 128'd1);
        check({tag, "_quiet"}, 128'(quiet_ok), 128'd1);
        if (exp_term != 1) begin
            check({tag, "_zero"}, rdata, '0);
        end else if (!we) begin
            mask = '0;
            for (int b = 0; b < 16; b++) if (m_known[idx][b]) mask[8*b +: 8] = 8'hFF;
            check({tag, "_rdata"}, rdata & mask, m_data[idx] & mask);
        end
        if (exp_term == 1 && we) begin
            for (int b = 0; b < 16; b++) begin
                if (sel[b]) begin
                    m_data[idx][8*b +: 8] = dat[8*b +: 8];
                    m_known[idx][b] = 1'b1;
                end
            end
        end
    endtask

    vec_t         tbl [15];
    int           term, lat;
    logic [127:0] rdata;
    bit           excl_ok, quiet_ok, saw;
    logic [31:0]  radr;
    logic [15:0]  rsel;
    int           r;

    initial begin
        // Reset holds every output low even with a request on the bus.
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_adr_i = 32'h10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset%0d_term", i), {125'd0, wb_ack_o, wb_err_o, wb_rty_o}, '0);
            check($sformatf("reset%0d_dat", i), wb_dat_o, '0);
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        rst = 1'b1;

`ifndef WB_MEM_RESPONDER_RETRY_EN
        tbl[0]  = '{32'h0000_0010, 1'b1, 16'hFFFF, D0, 1, '0};
        tbl[1]  = '{32'h0000_0010, 1'b0, 16'hFFFF, Junk, 1, D0};
        tbl[2]  = '{32'h0000_0030, 1'b1, 16'hFFFF, Ones, 1, '0};
        tbl[3]  = '{32'h0000_0030, 1'b1, 16'h000F, {Junk[127:32], 32'hDEADBEEF}, 1, '0};
        tbl[4]  = '{32'h0000_0030, 1'b0, 16'h0000, Junk, 1, {Ones[127:32], 32'hDEADBEEF}};
        tbl[5]  = '{32'h0000_0000, 1'b1, 16'hFFFF, D1, 1, '0};
        tbl[6]  = '{32'h0000_4000, 1'b0, 16'hFFFF, Junk, 2, '0};
        tbl[7]  = '{32'h0000_4000, 1'b1, 16'hFFFF, Junk, 2, '0};
        tbl[8]  = '{32'h0000_0000, 1'b0, 16'hFFFF, Junk, 1, D1};
        tbl[9]  = '{32'h0000_0010, 1'b1, 16'h0000, Junk, 1, '0};
        tbl[10] = '{32'h0000_001F, 1'b0, 16'hFFFF, Junk, 1, D0};
        tbl[11] = '{32'h0000_3FF0, 1'b1, 16'hFFFF, D2, 1, '0};
        tbl[12] = '{32'h0000_3FFC, 1'b0, 16'hFFFF, Junk, 1, D2};
        tbl[13] = '{32'hFFFF_FFF0, 1'b0, 16'hFFFF, Junk, 2, '0};
        tbl[14] = '{32'h0000_0020, 1'b1, 16'hFFFF, D3, 1, '0};

        for (int i = 0; i < 15; i++) begin
            bus_xfer(tbl[i].adr, tbl[i].we, tbl[i].sel, tbl[i].dat, 1'b0,
                     term, lat, rdata, excl_ok, quiet_ok);
            check($sformatf("tbl%0d_term", i), 128'(term), 128'(tbl[i].exp_term));
            check($sformatf("tbl%0d_lat", i), 128'(lat), 128'(Ws + 1));
            check($sformatf("tbl%0d_excl", i), 128'(excl_ok), 128'd1);
            check($sformatf("tbl%0d_quiet", i), 128'(quiet_ok), 128'd1);
            if (!tbl[i].we || tbl[i].exp_term == 2)
                check($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_data);
        end

        // Abort: drop cyc during the wait state of a write to 0x20.
        @(negedge clk);
        wb_adr_i = 32'h20;
        wb_we_i  = 1'b1;
        wb_sel_i = 16'hFFFF;
        wb_dat_i = D4;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        @(negedge clk);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (wb_ack_o || wb_err_o || wb_rty_o) saw = 1'b1;
            @(negedge clk);
        end
        check("abort_no_term", 128'(saw), 128'd0);
        bus_xfer(32'h20, 1'b0, 16'hFFFF, Junk, 1'b0, term, lat, rdata, excl_ok, quiet_ok);
        check("abort_read_term", 128'(term), 128'd1);
        check("abort_read_lat", 128'(lat), 128'(Ws + 1));
        check("abort_read_data", rdata, D3);

        // Reset asserted in the response cycle of a write.
        @(negedge clk);
        wb_adr_i = 32'h20;
        wb_we_i  = 1'b1;
        wb_sel_i = 16'hFFFF;
        wb_dat_i = D4;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rstresp_pre_ack", 128'(wb_ack_o), 128'd1);
        #1;
        rst = 1'b0;
        #1;
        check("rstresp_term", {125'd0, wb_ack_o, wb_err_o, wb_rty_o}, '0);
        check("rstresp_dat", wb_dat_o, '0);
        @(negedge clk);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus_xfer(32'h20, 1'b0, 16'hFFFF, Junk, 1'b0, term, lat, rdata, excl_ok, quiet_ok);
        check("rstresp_read_term", 128'(term), 128'd1);
        check("rstresp_read_data", rdata, D3);
`else
        // Five reads after reset: rty, ack, ack, ack, rty.
        for (int i = 0; i < 5; i++) begin
            bus_xfer(32'h0, 1'b0, 16'hFFFF, Junk, 1'b0, term, lat, rdata, excl_ok, quiet_ok);
            check($sformatf("retry%0d_term", i), 128'(term),
                  128'((i == 0 || i == 4) ? 3 : 1));
            check($sformatf("retry%0d_lat", i), 128'(lat), 128'(Ws + 1));
            if (i == 0 || i == 4) check($sformatf("retry%0d_zero", i), rdata, '0);
        end
`endif

        // Randomized traffic against the reference model, inputs scrambled after acceptance.
        do_reset();
        m_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            m_data[i]  = '0;
            m_known[i] = '0;
        end
        for (int i = 0; i < 8; i++) model_xfer(32'(i * 16), 1'b1, 16'hFFFF, rand128(), "init");
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) radr = $urandom() | 32'h0000_4000;
            else radr = 32'($urandom_range(0, 7) * 16 + $urandom_range(0, 15));
            r = int'($urandom_range(0, 3));
            rsel = (r == 0) ? 16'hFFFF : (r == 1) ? 16'h0000 : 16'($urandom());
            model_xfer(radr, 1'($urandom()), rsel, rand128(), $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
